cosine_vec_loader: RTL and testbench
====================================

COSINE_VEC_LOADER -- requirements
Module: cosine_vec_loader

Interface
REQ-001 Parameter W, default 5, is the number of elements per vector (W >= 1).
REQ-002 Parameter DW, default 32, is the element and result width in bits.
REQ-003 Parameter TIMEOUT, default 1024, is the number of cycles to wait for a result before flagging an error (TIMEOUT >= 2).
REQ-004 clk  input  1  is the single clock; all logic SHALL be rising-edge.
REQ-005 rst  input  1  is the reset: synchronous and active-high.
REQ-006 in_valid  input  1  signals that an element word is offered.
REQ-007 in_ready  output  1  signals that the loader can accept an element.
REQ-008 in_data  input  DW  is the element, in signed fixed-point Q.15.
REQ-009 vec_a  output  DW x W (unpacked [W-1:0])  is operand A, to the cosine_sim block.
REQ-010 vec_b  output  DW x W (unpacked [W-1:0])  is operand B, to the cosine_sim block.
REQ-011 start  output  1  is a one-cycle compute trigger to cosine_sim.
REQ-012 sim  input  DW  is the similarity result from cosine_sim.
REQ-013 sim_valid  input  1  is the result-valid strobe from cosine_sim.
REQ-014 res_valid  output  1  signals that a result is held for the consumer.
REQ-015 res_ready  input  1  signals that the consumer accepts the result.
REQ-016 res_data  output  DW  is the captured sim value.
REQ-017 res_err  output  1  is high with res_valid when the result timed out.

Function
REQ-018 The FSM SHALL have four states: LOAD, START, WAIT, RESULT.
REQ-019 The element index idx SHALL run from 0 to 2W-1, with width clog2(2W).
REQ-020 LOAD state:
- in_ready = 1.
- On each cycle with in_valid && in_ready, the element is accepted.
- idx < W: in_data is written to vec_a[idx].
- idx >= W: in_data is written to vec_b[idx-W].
- idx increments by 1 after each accepted element.
REQ-021 When element 2W-1 is accepted, idx SHALL wrap to 0 and the next state SHALL be START.
REQ-022 in_valid low in LOAD SHALL stall with no state change; there is no limit on gaps between elements.
REQ-023 START state SHALL drive start = 1 for exactly one cycle, then go to WAIT; sim_valid in START is ignored.
REQ-024 start SHALL be 0 in every state other than START.
REQ-025 In START, WAIT and RESULT: in_ready = 0, and vec_a/vec_b SHALL hold stable.
REQ-026 WAIT state:
- tcnt is cleared on entry and increments every cycle.
- If sim_valid = 1: res_data <= sim, res_err <= 0, go to RESULT.
- Else if tcnt == TIMEOUT-1: res_data <= 0, res_err <= 1, go to RESULT.
REQ-027 If sim_valid and timeout coincide in the same cycle, sim_valid SHALL win (res_err = 0).
REQ-028 RESULT state:
- res_valid = 1; res_data and res_err hold.
- On res_valid && res_ready, go to LOAD next cycle; in_ready rises that cycle.
REQ-029 sim_valid outside WAIT SHALL be ignored and SHALL NOT change res_data.
REQ-030 Latency: start SHALL assert on the cycle after the 2W-th element is accepted; res_valid SHALL assert on the cycle after sim_valid.
REQ-031 in_data and sim SHALL be passed through bit-exact, with no arithmetic or sign change.

Reset
REQ-032 When rst = 1 at a rising edge, the following SHALL apply next cycle:
- state = LOAD, idx = 0, tcnt = 0.
- start = 0, res_valid = 0, res_err = 0, res_data = 0.
- All vec_a/vec_b entries = 0.
- in_ready = 1 from the first cycle after rst deasserts.
REQ-033 rst asserted mid-load, in WAIT, or in RESULT SHALL abandon the transaction with no start pulse and no res_valid; a sim_valid arriving after reset is ignored.

Verification
REQ-034 Ten elements of 0x00008000 (1.0) back-to-back, then sim_valid with sim=0x3F800000 three cycles after start ->
- start pulses once, on the cycle after the 10th accept.
- vec_a[0..4] = vec_b[0..4] = 0x00008000.
- res_data = 0x3F800000, res_err = 0.
REQ-035 Elements with in_valid toggled every other cycle, vec_b = -vec_a (0xFFFF8000) ->
- Exactly 10 accepts.
- Correct vec_b contents.
- Single start pulse.
REQ-036 No sim_valid after start ->
- res_valid rises exactly TIMEOUT+1 cycles after start.
- res_err = 1, res_data = 0.
REQ-037 res_ready held low for 20 cycles in RESULT, with a stray sim_valid/sim=0x12345678 pulse ->
- res_valid, res_data and res_err stay unchanged.
- in_ready stays 0 until the cycle after res_ready.
REQ-038 rst pulsed after 6 accepted elements, then 10 fresh elements ->
- No start occurs before the 10th fresh element.
- vec_b[0] holds a fresh value.
REQ-039 sim_valid on the exact timeout cycle -> res_err = 0 and res_data = sim.

Source files
------------

// File: rtl/cosine_vec_loader.sv
// Collects 2W streamed Q.15 elements into two operand vectors, fires cosine_sim,
// then holds its result (or a timeout error) until the consumer takes it.
module cosine_vec_loader #(
   parameter int W       = 5,
   parameter int DW      = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic [DW-1:0] vec_a [W-1:0],
   output logic [DW-1:0] vec_b [W-1:0],
   output logic          start,
   input  logic [DW-1:0] sim,
   input  logic          sim_valid,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [DW-1:0] res_data,
   output logic          res_err
);

   localparam int IDX_W = $clog2(2 * W);
   localparam int TC_W  = $clog2(TIMEOUT);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2 * W - 1);
   localparam logic [TC_W-1:0]  TC_LAST  = TC_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      START  = 2'd1,
      WAIT   = 2'd2,
      RESULT = 2'd3
   } state_t;

   state_t           state_r;
   logic [IDX_W-1:0] idx_r;
   logic [TC_W-1:0]  tcnt_r;
   logic             in_ready_r;
   logic             start_r;
   logic             res_valid_r;
   logic [DW-1:0]    res_data_r;
   logic             res_err_r;
   logic [DW-1:0]    vec_a_r [W-1:0];
   logic [DW-1:0]    vec_b_r [W-1:0];

   // Control FSM; every output is a register updated alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= LOAD;
         idx_r       <= '0;
         tcnt_r      <= '0;
         in_ready_r  <= 1'b1;
         start_r     <= 1'b0;
         res_valid_r <= 1'b0;
         res_data_r  <= '0;
         res_err_r   <= 1'b0;
         for (int i = 0; i < W; i++) begin
            vec_a_r[i] <= '0;
            vec_b_r[i] <= '0;
         end
      end else begin
         case (state_r)
            LOAD: begin
               if (in_valid && in_ready_r) begin
                  // Flat index: first W words go to A, the next W to B.
                  for (int i = 0; i < W; i++) begin
                     if (idx_r == IDX_W'(i)) begin
                        vec_a_r[i] <= in_data;
                     end
                     if (idx_r == IDX_W'(i + W)) begin
                        vec_b_r[i] <= in_data;
                     end
                  end
                  if (idx_r == IDX_LAST) begin
                     idx_r      <= '0;
                     in_ready_r <= 1'b0;
                     start_r    <= 1'b1;
                     state_r    <= START;
                  end else begin
                     idx_r <= idx_r + 1'b1;
                  end
               end else begin
                  idx_r <= idx_r;
               end
            end
            START: begin
               start_r <= 1'b0;
               tcnt_r  <= '0;
               state_r <= WAIT;
            end
            WAIT: begin
               // A result arriving on the timeout cycle still counts as good.
               if (sim_valid) begin
                  res_data_r  <= sim;
                  res_err_r   <= 1'b0;
                  res_valid_r <= 1'b1;
                  tcnt_r      <= '0;
                  state_r     <= RESULT;
               end else if (tcnt_r == TC_LAST) begin
                  res_data_r  <= '0;
                  res_err_r   <= 1'b1;
                  res_valid_r <= 1'b1;
                  tcnt_r      <= '0;
                  state_r     <= RESULT;
               end else begin
                  tcnt_r <= tcnt_r + 1'b1;
               end
            end
            RESULT: begin
               if (res_valid_r && res_ready) begin
                  res_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= LOAD;
               end else begin
                  res_valid_r <= 1'b1;
               end
            end
            default: begin
               state_r     <= LOAD;
               idx_r       <= '0;
               tcnt_r      <= '0;
               in_ready_r  <= 1'b1;
               start_r     <= 1'b0;
               res_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign start     = start_r;
   assign res_valid = res_valid_r;
   assign res_data  = res_data_r;
   assign res_err   = res_err_r;
   assign vec_a     = vec_a_r;
   assign vec_b     = vec_b_r;

endmodule

// File: tb/tb_cosine_vec_loader.sv
// Directed, table-driven bench for cosine_vec_loader with hand-computed expectations.
module tb_cosine_vec_loader;

   localparam int W  = 5;
   localparam int DW = 32;
   localparam int TO = 1024;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [DW-1:0] vec_a [W-1:0];
   logic [DW-1:0] vec_b [W-1:0];
   logic          start;
   logic [DW-1:0] sim;
   logic          sim_valid;
   logic          res_valid;
   logic          res_ready;
   logic [DW-1:0] res_data;
   logic          res_err;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [9:0][31:0] e;
      bit               gap;
      int               d;
      logic [31:0]      simv;
      bit               stray;
      int               hold;
      logic [31:0]      exp_data;
      logic             exp_err;
      int               exp_lat;
   } txn_t;

   txn_t tbl [5];

   cosine_vec_loader #(.W(W), .DW(DW), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .vec_a     (vec_a),
      .vec_b     (vec_b),
      .start     (start),
      .sim       (sim),
      .sim_valid (sim_valid),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_err   (res_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_vecs(input logic [9:0][31:0] e);
      for (int i = 0; i < W; i++) begin
         chk($sformatf("vec_a[%0d]", i), vec_a[i], e[i]);
         chk($sformatf("vec_b[%0d]", i), vec_b[i], e[i + W]);
      end
   endtask

   task automatic reset_checks();
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_start", {31'b0, start}, 32'd0);
      chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
      chk("rst_res_err", {31'b0, res_err}, 32'd0);
      chk("rst_res_data", res_data, 32'h0000_0000);
      chk_vecs('0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      sim_valid = 1'b0;
      res_ready = 1'b0;
      tick();
      rst = 1'b0;
      reset_checks();
   endtask

   // Offers n elements; start must appear only right after the 10th accept.
   task automatic load_vec(input logic [9:0][31:0] e, input int n, input bit gap);
      int acc = 0;
      for (int k = 0; k < n; k++) begin
         if (gap) begin
            in_valid = 1'b0;
            in_data  = 32'hAAAA_AAAA;
            tick();
         end
         in_valid = 1'b1;
         in_data  = e[k];
         if (in_valid && in_ready) acc++;
         tick();
         chk("start_timing", {31'b0, start}, (k == 2 * W - 1) ? 32'd1 : 32'd0);
      end
      in_valid = 1'b0;
      chk("accept_count", 32'(acc), 32'(n));
   endtask

   // Called on the start cycle; drives sim_valid d cycles after start.
   task automatic run_wait(input txn_t t);
      int n = 0;
      int starts = 0;
      if (t.stray) begin
         sim_valid = 1'b1;
         sim = 32'hDEAD_BEEF;
      end
      tick();
      n = 1;
      sim_valid = 1'b0;
      while (!res_valid && n < TO + 8) begin
         if (start) starts++;
         if (n == t.d) begin
            sim_valid = 1'b1;
            sim = t.simv;
         end
         tick();
         n++;
         sim_valid = 1'b0;
      end
      chk("start_once", 32'(starts), 32'd0);
      chk("res_latency", 32'(n), 32'(t.exp_lat));
      chk("res_valid", {31'b0, res_valid}, 32'd1);
      chk("res_data", res_data, t.exp_data);
      chk("res_err", {31'b0, res_err}, {31'b0, t.exp_err});
      chk_vecs(t.e);
   endtask

   task automatic run_result(input logic [31:0] exp_data, input logic exp_err, input int hold);
      res_ready = 1'b0;
      for (int j = 0; j < hold; j++) begin
         if (j == hold / 2) begin
            sim_valid = 1'b1;
            sim = 32'h1234_5678;
         end
         tick();
         sim_valid = 1'b0;
         chk("hold_valid", {31'b0, res_valid}, 32'd1);
         chk("hold_data", res_data, exp_data);
         chk("hold_err", {31'b0, res_err}, {31'b0, exp_err});
         chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
      end
      res_ready = 1'b1;
      chk("in_ready_before_ack", {31'b0, in_ready}, 32'd0);
      tick();
      res_ready = 1'b0;
      chk("in_ready_after_ack", {31'b0, in_ready}, 32'd1);
      chk("res_valid_cleared", {31'b0, res_valid}, 32'd0);
   endtask

   initial begin
      txn_t tr;
      logic [9:0][31:0] f;

      rst = 1'b1;
      in_valid = 1'b0;
      in_data = 32'h0000_0000;
      sim = 32'h7777_7777;
      sim_valid = 1'b0;
      res_ready = 1'b0;

      for (int k = 0; k < 2 * W; k++) begin
         tbl[0].e[k] = 32'h0000_8000;
         tbl[1].e[k] = (k < W) ? 32'h0000_8000 : 32'hFFFF_8000;
         tbl[2].e[k] = 32'h1000_0000 + 32'(k);
         tbl[3].e[k] = 32'hA5A5_0000 + 32'(k);
         tbl[4].e[k] = 32'h8000_0001 + 32'(k) * 32'h0000_0101;
         f[k]        = 32'h0000_1111 * 32'(k + 1);
      end
      tbl[0].gap = 1'b0; tbl[0].d = 3;  tbl[0].simv = 32'h3F80_0000; tbl[0].stray = 1'b0;
      tbl[0].hold = 0;   tbl[0].exp_data = 32'h3F80_0000; tbl[0].exp_err = 1'b0; tbl[0].exp_lat = 4;
      tbl[1].gap = 1'b1; tbl[1].d = 1;  tbl[1].simv = 32'hBF80_0000; tbl[1].stray = 1'b0;
      tbl[1].hold = 20;  tbl[1].exp_data = 32'hBF80_0000; tbl[1].exp_err = 1'b0; tbl[1].exp_lat = 2;
      tbl[2].gap = 1'b0; tbl[2].d = -1; tbl[2].simv = 32'h7777_7777; tbl[2].stray = 1'b0;
      tbl[2].hold = 2;   tbl[2].exp_data = 32'h0000_0000; tbl[2].exp_err = 1'b1; tbl[2].exp_lat = TO + 1;
      tbl[3].gap = 1'b0; tbl[3].d = TO; tbl[3].simv = 32'h0000_ABCD; tbl[3].stray = 1'b0;
      tbl[3].hold = 0;   tbl[3].exp_data = 32'h0000_ABCD; tbl[3].exp_err = 1'b0; tbl[3].exp_lat = TO + 1;
      tbl[4].gap = 1'b1; tbl[4].d = 2;  tbl[4].simv = 32'h7FFF_FFFF; tbl[4].stray = 1'b1;
      tbl[4].hold = 3;   tbl[4].exp_data = 32'h7FFF_FFFF; tbl[4].exp_err = 1'b0; tbl[4].exp_lat = 3;

      do_reset();

      for (int i = 0; i < 5; i++) begin
         load_vec(tbl[i].e, 2 * W, tbl[i].gap);
         chk_vecs(tbl[i].e);
         run_wait(tbl[i]);
         run_result(tbl[i].exp_data, tbl[i].exp_err, tbl[i].hold);
      end

      // Reset after six accepts, then a complete fresh load.
      load_vec(tbl[2].e, 6, 1'b0);
      do_reset();
      load_vec(f, 2 * W, 1'b0);
      chk_vecs(f);
      chk("vec_b0_fresh", vec_b[0], 32'h0000_6666);
      tr = tbl[0];
      tr.e = f;
      tr.d = 1;
      tr.simv = 32'h0000_C000;
      tr.exp_data = 32'h0000_C000;
      tr.exp_lat = 2;
      run_wait(tr);
      run_result(32'h0000_C000, 1'b0, 0);

      // Reset while waiting; a late sim_valid must be ignored.
      load_vec(tbl[0].e, 2 * W, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sim_valid = 1'b1;
      sim = 32'h5555_5555;
      tick();
      sim_valid = 1'b0;
      tick();
      reset_checks();

      // Reset while a result is held.
      load_vec(tbl[1].e, 2 * W, 1'b0);
      tr = tbl[1];
      tr.simv = 32'h0F0F_0F0F;
      tr.exp_data = 32'h0F0F_0F0F;
      run_wait(tr);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      reset_checks();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
